// File: rtl/neuron_param_loader.sv
// Host-side loader for neuron weight/bias parameters: parses a header word, then
// streams N weights and one bias into the neuron array as one-cycle strobes.
module neuron_param_loader #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned maxWeight = 784
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 abort,
  output logic [dataWidth-1:0] mWeight,
  output logic                 mWeightValid,
  output logic [31:0]          mBias,
  output logic                 mBiasValid,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic                 load_done,
  output logic                 load_err
);

  typedef enum logic [2:0] {StIdle, StWeight, StBias, StDone, StDrain} state_e;

  localparam logic [16:0] MaxW = 17'(maxWeight);

  state_e                 state_q;
  logic [16:0]            cnt_q;
  logic [dataWidth-1:0]   weight_q;
  logic                   weight_vld_q;
  logic [31:0]            bias_q;
  logic                   bias_vld_q;
  logic [7:0]             layer_q;
  logic [7:0]             neuron_q;
  logic                   done_q;
  logic                   err_q;

  logic                   beat;
  logic [16:0]            hdr_cnt;

  assign s_ready = (state_q != StDone);
  // Abort wins over a same-cycle beat, including a header beat in idle.
  assign beat    = s_valid & s_ready & ~abort;
  assign hdr_cnt = {1'b0, s_data[15:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      weight_q     <= '0;
      weight_vld_q <= 1'b0;
      bias_q       <= '0;
      bias_vld_q   <= 1'b0;
      layer_q      <= '0;
      neuron_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      weight_vld_q <= 1'b0;
      bias_vld_q   <= 1'b0;
      done_q       <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
      end else if (beat) begin
        case (state_q)
          StIdle: begin
            layer_q  <= s_data[31:24];
            neuron_q <= s_data[23:16];
            err_q    <= 1'b0;
            if (hdr_cnt == 17'd0) begin
              cnt_q   <= '0;
              state_q <= StBias;
            end else if (hdr_cnt <= MaxW) begin
              cnt_q   <= hdr_cnt;
              state_q <= StWeight;
            end else begin
              // Swallow the whole oversized load: N weights plus the bias word.
              err_q   <= 1'b1;
              cnt_q   <= hdr_cnt + 17'd1;
              state_q <= StDrain;
            end
          end
          StWeight: begin
            weight_q     <= s_data[dataWidth-1:0];
            weight_vld_q <= 1'b1;
            cnt_q        <= cnt_q - 17'd1;
            if (cnt_q == 17'd1) state_q <= StBias;
          end
          StBias: begin
            bias_q     <= s_data;
            bias_vld_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
          StDrain: begin
            cnt_q <= cnt_q - 17'd1;
            if (cnt_q == 17'd1) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q == StDone) begin
        state_q <= StIdle;
      end
    end
  end

  assign mWeight           = weight_q;
  assign mWeightValid      = weight_vld_q;
  assign mBias             = bias_q;
  assign mBiasValid        = bias_vld_q;
  assign config_layer_num  = {24'd0, layer_q};
  assign config_neuron_num = {24'd0, neuron_q};
  assign load_done         = done_q;
  assign load_err          = err_q;

endmodule
